mac_column_ctrl: RTL and testbench

Sequencer for one signed MAC column. On each start command it fetches the image and weight columns for every output pixel from the on-chip buffers and registers them into the MAC column inputs. It accumulates the column partial sums across the kernel width and hands each finished pixel sum downstream over a valid/ready handshake. It sits between the image/weight buffers and the output/activation buffer.

---
 rtl/mac_column_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mac_column_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_column_ctrl.sv
// Sequencer for one signed MAC column: fetches image/weight columns, accumulates
// column psums over the kernel width, emits pixel sums. Optional ReLU: MAC_CTRL_RELU_EN.
module mac_column_ctrl #(
  parameter int DATA_WIDTH       = 8,
  parameter int COLUMN_NUM       = 6,
  parameter int COLUMN_OUT_WIDTH = 2*DATA_WIDTH+3,
  parameter int KERNEL_COLS      = 6,
  parameter int ACC_WIDTH        = COLUMN_OUT_WIDTH+3,
  parameter int ADDR_WIDTH       = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_start,
  input  logic [ADDR_WIDTH-1:0]            i_num_out,
  input  logic [ADDR_WIDTH-1:0]            i_img_base,
  input  logic [ADDR_WIDTH-1:0]            i_wgt_base,
  input  logic [ADDR_WIDTH-1:0]            i_stride,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_rd_en,
  output logic [ADDR_WIDTH-1:0]            o_img_addr,
  output logic [ADDR_WIDTH-1:0]            o_wgt_addr,
  input  logic [DATA_WIDTH*COLUMN_NUM-1:0] i_img_column,
  input  logic [DATA_WIDTH*COLUMN_NUM-1:0] i_wgt_column,
  output logic [DATA_WIDTH*COLUMN_NUM-1:0] o_mac_img,
  output logic [DATA_WIDTH*COLUMN_NUM-1:0] o_mac_wgt,
  input  logic [COLUMN_OUT_WIDTH-1:0]      i_psum_column,
  output logic [ACC_WIDTH-1:0]             o_psum,
  output logic                             o_psum_valid,
  input  logic                             i_psum_ready
);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, OUT, FINISH} state_t;

  state_t                       state;
  logic [ADDR_WIDTH-1:0]        num_out, wgt_base, stride, pix, row;
  logic [3:0]                   col;
  logic                         drain_cnt;
  logic                         rd_first;
  logic [1:0]                   vld_pipe, first_pipe;
  logic signed [ACC_WIDTH-1:0]  acc, acc_next, psum_ext, psum_out;

  assign psum_ext = {{(ACC_WIDTH-COLUMN_OUT_WIDTH){i_psum_column[COLUMN_OUT_WIDTH-1]}},
                     i_psum_column};

  // The final column lands on the same edge OUT is entered, so o_psum takes acc_next.
  always_comb begin
    acc_next = acc;
    if (vld_pipe[1])
      acc_next = first_pipe[1] ? psum_ext : acc + psum_ext;
  end

`ifdef MAC_CTRL_RELU_EN
  assign psum_out = acc_next[ACC_WIDTH-1] ? '0 : acc_next;
`else
  assign psum_out = acc_next;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      num_out      <= '0;
      wgt_base     <= '0;
      stride       <= '0;
      pix          <= '0;
      row          <= '0;
      col          <= '0;
      drain_cnt    <= 1'b0;
      rd_first     <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_rd_en      <= 1'b0;
      o_img_addr   <= '0;
      o_wgt_addr   <= '0;
      o_psum       <= '0;
      o_psum_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          num_out  <= i_num_out;
          wgt_base <= i_wgt_base;
          stride   <= i_stride;
          pix      <= '0;
          row      <= i_img_base;
          o_busy   <= 1'b1;
          if (i_num_out == '0) begin
            state  <= FINISH;
            o_done <= 1'b1;
          end else begin
            state      <= FETCH;
            o_rd_en    <= 1'b1;
            rd_first   <= 1'b1;
            col        <= '0;
            o_img_addr <= i_img_base;
            o_wgt_addr <= i_wgt_base;
          end
        end
        FETCH: begin
          rd_first <= 1'b0;
          if (col == 4'(KERNEL_COLS-1)) begin
            state     <= DRAIN;
            o_rd_en   <= 1'b0;
            drain_cnt <= 1'b0;
          end else begin
            col        <= col + 4'd1;
            o_img_addr <= o_img_addr + 1'b1;
            o_wgt_addr <= o_wgt_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            state        <= OUT;
            o_psum       <= psum_out;
            o_psum_valid <= 1'b1;
          end
          drain_cnt <= 1'b1;
        end
        OUT: if (i_psum_ready) begin
          o_psum_valid <= 1'b0;
          if (pix == num_out - 1'b1) begin
            state  <= FINISH;
            o_done <= 1'b1;
          end else begin
            state      <= FETCH;
            pix        <= pix + 1'b1;
            row        <= row + stride;
            o_rd_en    <= 1'b1;
            rd_first   <= 1'b1;
            col        <= '0;
            o_img_addr <= row + stride;
            o_wgt_addr <= wgt_base;
          end
        end
        FINISH: begin
          state  <= IDLE;
          o_done <= 1'b0;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read strobe -> buffer data valid -> MAC result valid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_pipe   <= '0;
      first_pipe <= '0;
      o_mac_img  <= '0;
      o_mac_wgt  <= '0;
      acc        <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[0], o_rd_en};
      first_pipe <= {first_pipe[0], rd_first};
      if (vld_pipe[0]) begin
        o_mac_img <= i_img_column;
        o_mac_wgt <= i_wgt_column;
      end
      acc <= acc_next;
    end
  end

endmodule

// File: tb/tb_mac_column_ctrl.sv
// Directed bench for mac_column_ctrl with buffer/MAC models and a per-cycle checker.
`timescale 1ns/1ps
module tb_mac_column_ctrl;
  localparam int DW = 8, CN = 6, COW = 2*DW+3, K = 6, ACCW = COW+3, AW = 8;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, ready = 1'b1;
  logic [AW-1:0] num_out = '0, img_base = '0, wgt_base = '0, stride = '0;
  logic busy, done, rd_en, psum_valid;
  logic [AW-1:0] img_addr, wgt_addr;
  logic [DW*CN-1:0] img_col = '0, wgt_col = '0, mac_img, mac_wgt;
  logic [COW-1:0] psum_col;
  logic [ACCW-1:0] psum;

  mac_column_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_num_out(num_out),
    .i_img_base(img_base), .i_wgt_base(wgt_base), .i_stride(stride),
    .o_busy(busy), .o_done(done), .o_rd_en(rd_en), .o_img_addr(img_addr),
    .o_wgt_addr(wgt_addr), .i_img_column(img_col), .i_wgt_column(wgt_col),
    .o_mac_img(mac_img), .o_mac_wgt(mac_wgt), .i_psum_column(psum_col),
    .o_psum(psum), .o_psum_valid(psum_valid), .i_psum_ready(ready));

  always #5 clk = ~clk;

  logic [DW*CN-1:0] img_mem [256];
  logic [DW*CN-1:0] wgt_mem [256];

  function automatic int colsum(logic [DW*CN-1:0] a, logic [DW*CN-1:0] b);
    int s = 0;
    for (int i = 0; i < CN; i++) begin
      logic [7:0] x;
      logic signed [7:0] y;
      x = a[i*DW +: DW];
      y = b[i*DW +: DW];
      s += int'(x) * int'(y);
    end
    return s;
  endfunction

  function automatic longint relu(longint v);
`ifdef MAC_CTRL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // buffer with one-cycle read latency, combinational MAC column
  always @(posedge clk) if (rd_en) begin
    img_col <= img_mem[img_addr];
    wgt_col <= wgt_mem[wgt_addr];
  end
  assign psum_col = COW'(colsum(mac_img, mac_wgt));

  int total = 0, bad = 0, cyc = 0, start_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // reference model: expected address stream and pixel sums per job
  int exp_img[$], exp_wgt[$], obs_img[$];
  longint exp_sum[$];

  task automatic model_job(int n, int ib, int wb, int st);
    for (int p = 0; p < n; p++) begin
      longint s = 0;
      for (int k = 0; k < K; k++) begin
        int ia, wa;
        ia = (ib + p*st + k) % 256;
        wa = (wb + k) % 256;
        exp_img.push_back(ia);
        exp_wgt.push_back(wa);
        s += colsum(img_mem[ia], wgt_mem[wa]);
      end
      exp_sum.push_back(relu(s));
    end
  endtask

  int rd_cnt = 0, done_cnt = 0, valid_rel = -1, done_rel = -1, hs_cyc = 0;
  bit prev_valid = 0, prev_hs = 0, prev_rd = 0, hs_seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 0; prev_hs = 0; prev_rd = 0; hs_seen = 0;
    end else begin
      if (rd_en) begin
        rd_cnt++;
        obs_img.push_back(int'(img_addr));
        if (exp_img.size() == 0) chk("unexpected_read", 1, 0);
        else begin
          chk("img_addr", img_addr, exp_img.pop_front());
          chk("wgt_addr", wgt_addr, exp_wgt.pop_front());
        end
        if (!prev_rd && hs_seen) begin
          chk("fetch_after_handshake", cyc - hs_cyc, 1);
          hs_seen = 0;
        end
        if (psum_valid) chk("read_during_out", 1, 0);
      end
      if (prev_valid && !prev_hs) chk("valid_held", psum_valid, 1);
      if (psum_valid) begin
        if (valid_rel < 0) valid_rel = cyc - start_cyc + 1;
        if (exp_sum.size() == 0) chk("unexpected_psum", 1, 0);
        else chk("psum", $signed(psum), exp_sum[0]);
        if (ready) begin
          if (exp_sum.size() != 0) void'(exp_sum.pop_front());
          hs_seen = 1;
          hs_cyc = cyc;
        end
      end
      if (done) begin
        done_cnt++;
        hs_seen = 0;
        if (done_rel < 0) done_rel = cyc - start_cyc + 1;
      end
      prev_valid = psum_valid;
      prev_hs = psum_valid && ready;
      prev_rd = rd_en;
    end
  end

  task automatic start_job(int n, int ib, int wb, int st);
    @(posedge clk); #1;
    num_out = AW'(n); img_base = AW'(ib); wgt_base = AW'(wb); stride = AW'(st);
    start = 1'b1;
    valid_rel = -1; done_rel = -1;
    @(posedge clk); #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(string nm);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 300) begin @(posedge clk); n++; end
    chk({nm, "_done_seen"}, done_cnt - d0, 1);
    @(posedge clk); #1;
    chk({nm, "_model_drained"}, exp_img.size() + exp_sum.size(), 0);
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_rd_en"}, rd_en, 0);
    chk({nm, "_addrs"}, {img_addr, wgt_addr}, 0);
    chk({nm, "_mac"}, {mac_img, mac_wgt}, 0);
    chk({nm, "_psum"}, psum, 0);
    chk({nm, "_valid"}, psum_valid, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int r0, d0, lit[18], n;
    for (int a = 0; a < 256; a++)
      for (int i = 0; i < CN; i++) begin
        img_mem[a][i*DW +: DW] = 8'(a*7 + i*13 + 3);
        wgt_mem[a][i*DW +: DW] = 8'(a*5 + i*29 + 1);
      end
    for (int a = 20; a < 26; a++) begin img_mem[a] = {CN{8'd1}}; wgt_mem[a] = {CN{8'd2}}; end
    for (int a = 100; a < 106; a++) img_mem[a] = {CN{8'hFF}};
    for (int a = 50; a < 56; a++) wgt_mem[a] = {CN{8'hFF}};

    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    rst = 1'b0;

    // basic sum: 6 columns x 12 = 72, valid at cycle 9, done at cycle 10
    model_job(1, 20, 20, 0);
    chk("model_basic_sum", exp_sum[0], 72);
    r0 = rd_cnt;
    start_job(1, 20, 20, 0);
    wait_done("basic");
    chk("basic_valid_cycle", valid_rel, 9);
    chk("basic_done_cycle", done_rel, 10);
    chk("basic_reads", rd_cnt - r0, 6);

    // negative sum
    model_job(1, 100, 50, 0);
`ifdef MAC_CTRL_RELU_EN
    chk("model_negative_sum", exp_sum[0], 0);
`else
    chk("model_negative_sum", exp_sum[0], -9180);
`endif
    start_job(1, 100, 50, 0);
    wait_done("negative");

    // address sequence across the 8-bit wrap
    lit = '{250,251,252,253,254,255, 254,255,0,1,2,3, 2,3,4,5,6,7};
    model_job(3, 250, 10, 4);
    r0 = rd_cnt;
    obs_img.delete();
    start_job(3, 250, 10, 4);
    wait_done("wrap");
    chk("wrap_reads", rd_cnt - r0, 18);
    for (int i = 0; i < 18; i++)
      chk("wrap_img_addr_list", (i < obs_img.size()) ? obs_img[i] : -1, lit[i]);
    chk("wrap_pixel_period_done", done_rel, 3*(K+3) + 1);

    // backpressure: ready low for 5 OUT cycles on pixel 0
    model_job(2, 30, 40, 6);
    r0 = rd_cnt;
    ready = 1'b0;
    start_job(2, 30, 40, 6);
    n = 0;
    while (!psum_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_valid_seen", psum_valid, 1);
    repeat (5) @(posedge clk);
    #1 ready = 1'b1;
    wait_done("backpressure");
    chk("bp_reads", rd_cnt - r0, 12);
    chk("bp_done_cycle", done_rel, 2*(K+3) + 5 + 1);

    // zero-length job
    r0 = rd_cnt;
    start_job(0, 0, 0, 0);
    wait_done("zero");
    chk("zero_done_cycle", done_rel, 1);
    chk("zero_reads", rd_cnt - r0, 0);

    // start pulsed mid-job with a different configuration is ignored
    model_job(2, 60, 70, 3);
    r0 = rd_cnt;
    d0 = done_cnt;
    start_job(2, 60, 70, 3);
    @(posedge clk); #1;
    num_out = 8'd5; img_base = 8'd0; wgt_base = 8'd0; stride = 8'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ignored_start_busy", busy, 1);
    wait_done("ignored_start");
    chk("ignored_start_reads", rd_cnt - r0, 12);
    chk("ignored_start_dones", done_cnt - d0, 1);

    // reset during DRAIN of pixel 2 of 4
    model_job(4, 80, 90, 2);
    start_job(4, 80, 90, 2);
    n = 0;
    while ((cyc - start_cyc + 1) != 16 && n < 50) begin @(posedge clk); #1; n++; end
    chk("reset_reached_drain", cyc - start_cyc + 1, 16);
    chk("reset_not_reading", rd_en, 0);
    rst = 1'b1;
    #1 chk_zero("midreset");
    d0 = done_cnt;
    exp_img.delete(); exp_wgt.delete(); exp_sum.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("midreset_no_done", done_cnt - d0, 0);
    chk("midreset_idle", busy, 0);
    model_job(2, 80, 90, 2);
    start_job(2, 80, 90, 2);
    wait_done("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
